multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle RV32I control decoder. It sequences each instruction through a Moore FSM with a memory request/ready handshake and a wait-state timeout. It adds full branch compare (BLT/BGE/BLTU/BGEU), illegal-instruction and timeout trapping, and a retire pulse. It sits between the instruction register, the shared instruction/data memory port, and the datapath muxes and enables.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction/flag inputs, memory handshake, and datapath
// enables/mux selects. The controller takes the master side.
interface multicycle_control_if;
  logic [31:0] Instr;
  logic        EQ;
  logic        LT;
  logic        LTU;
  logic        mem_ready;
  logic        mem_req;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUctrl;
  logic [1:0]  ResultSrc;
  logic [2:0]  ImmSrc;
  logic        retire;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    input  Instr, EQ, LT, LTU, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc,
           retire, trap, trap_cause
  );

  modport slave (
    output Instr, EQ, LT, LTU, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc,
           retire, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences each instruction through a Moore FSM,
// handshakes the shared memory port with a wait-state timeout, and traps on faults.
module multicycle_control #(
  parameter int MEM_TIMEOUT    = 15,
  parameter bit HAS_BRANCH_EXT = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_TRAP
  } state_t;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]    cause_q, cause_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_load, is_store, is_rtype, is_itype, is_lui, is_branch, is_jal, is_jalr;
  logic alu_f3_ok, br_f3_ok, taken;
  logic mem_req_c, stalled, timeout_hit;
  logic unused_instr_bits;

  assign opcode    = bus.Instr[6:0];
  assign funct3    = bus.Instr[14:12];
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_rtype  = (opcode == 7'b0110011);
  assign is_itype  = (opcode == 7'b0010011);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3[2:1] == 2'b00) || (funct3[2] && HAS_BRANCH_EXT);

  // Register/immediate fields are consumed by the datapath, not the controller.
  assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  always_comb begin
    case (funct3)
      3'b000:  taken = bus.EQ;
      3'b001:  taken = ~bus.EQ;
      3'b100:  taken = bus.LT;
      3'b101:  taken = ~bus.LT;
      3'b110:  taken = bus.LTU;
      3'b111:  taken = ~bus.LTU;
      default: taken = 1'b0;
    endcase
  end

  assign mem_req_c   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign stalled     = mem_req_c && !bus.mem_ready;
  // Ready arriving on the limit cycle clears 'stalled', so the access completes instead.
  assign timeout_hit = (MEM_TIMEOUT != 0) && stalled && (wait_cnt_q == LIMIT_M1);
  assign wait_cnt_d  = stalled ? wait_cnt_q + CW'(1) : '0;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_load || is_store)                            state_d = S_MEMADR;
        else if (((is_rtype || is_itype) && alu_f3_ok) || is_lui) state_d = S_EXEC;
        else if (is_branch && br_f3_ok)                     state_d = S_BRANCH;
        else if (is_jal)                                    state_d = S_JAL;
        else if (is_jalr)                                   state_d = S_JALRADR;
        else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_MEMADR:  state_d = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JALRADR: state_d = S_JAL;
      S_JAL:     state_d = S_ALUWB;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // Outputs decode straight from state so an async reset drops requests at once.
  always_comb begin
    bus.mem_req    = mem_req_c;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUctrl    = 3'b000;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.retire     = 1'b0;
    bus.trap       = (state_q == S_TRAP);
    bus.trap_cause = cause_q;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        if (is_branch)   bus.ImmSrc = 3'b010;
        else if (is_jal) bus.ImmSrc = 3'b011;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = is_store ? 3'b001 : 3'b000;
      end
      S_MEMRD: bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.retire   = bus.mem_ready;
      end
      S_EXEC: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = is_rtype ? 2'b00 : 2'b01;
        bus.ImmSrc  = is_lui ? 3'b100 : 3'b000;
        if (is_lui) bus.ALUctrl = 3'b111;
        else begin
          case (funct3)
            3'b000:  bus.ALUctrl = (bus.Instr[30] & bus.Instr[5]) ? 3'b001 : 3'b000;
            3'b010:  bus.ALUctrl = 3'b101;
            3'b110:  bus.ALUctrl = 3'b011;
            3'b111:  bus.ALUctrl = 3'b010;
            default: bus.ALUctrl = 3'b000;
          endcase
        end
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUctrl = 3'b001;
        bus.PCWrite = taken;
        bus.retire  = 1'b1;
      end
      S_JALRADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_JAL: begin
        bus.PCWrite = 1'b1;
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances (default, no branch
// extension, MEM_TIMEOUT=4) share stimulus; one is observed at a time.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        eq, lt, ltu, rdy;
  logic [1:0]  sel;
  logic [21:0] obs [3];
  logic [21:0] obs_sel;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus [3] ();

  // Observed word: {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,
  //                 ALUSrcA,ALUSrcB,ALUctrl,ResultSrc,ImmSrc,retire,trap,trap_cause}
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign bus[gi].Instr     = instr;
      assign bus[gi].EQ        = eq;
      assign bus[gi].LT        = lt;
      assign bus[gi].LTU       = ltu;
      assign bus[gi].mem_ready = rdy;
      multicycle_control #(
        .MEM_TIMEOUT   ((gi == 2) ? 4 : 15),
        .HAS_BRANCH_EXT(gi != 1)
      ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus[gi])
      );
      assign obs[gi] = {bus[gi].mem_req, bus[gi].MemWrite, bus[gi].AdrSrc, bus[gi].IRWrite,
                        bus[gi].PCWrite, bus[gi].RegWrite, bus[gi].ALUSrcA, bus[gi].ALUSrcB,
                        bus[gi].ALUctrl, bus[gi].ResultSrc, bus[gi].ImmSrc, bus[gi].retire,
                        bus[gi].trap, bus[gi].trap_cause};
    end
  endgenerate

  always_comb obs_sel = obs[sel];

  localparam logic [21:0] ZERO     = '0;
  localparam logic [21:0] F_RDY    = {6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 4'b0000};
  localparam logic [21:0] F_WAIT   = {6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 4'b0000};
  localparam logic [21:0] DEC      = {6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] DEC_B    = {6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 3'b010, 4'b0000};
  localparam logic [21:0] EXEC_R   = {6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] EXEC_SUB = {6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] ALUWB    = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b1000};
  localparam logic [21:0] MADR_L   = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] MADR_S   = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 4'b0000};
  localparam logic [21:0] MEMRD    = {6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] MEMWB    = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 4'b1000};
  localparam logic [21:0] MWR_RDY  = {6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b1000};
  localparam logic [21:0] MWR_WAIT = {6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] BR_T     = {6'b000010, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, 4'b1000};
  localparam logic [21:0] BR_N     = {6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, 4'b1000};
  localparam logic [21:0] JALRADR  = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] JAL      = {6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 4'b0000};
  localparam logic [21:0] TRAP_ILL = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b0101};
  localparam logic [21:0] TRAP_TO  = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 4'b0110};

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [21:0] exp);
    @(negedge clk);
    rdy = r;
    #1;
    chk(tag, obs_sel, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset", obs_sel, ZERO);
    rst = 1'b0;
    #1;
    chk("idle", obs_sel, ZERO);
  endtask

  initial begin
    rst = 1'b1; instr = '0; eq = 1'b0; lt = 1'b0; ltu = 1'b0; rdy = 1'b1; sel = 2'd0;

    instr = 32'h002081B3;  // add x3,x1,x2
    do_reset();
    cyc("add_fetch", 1, F_RDY); cyc("add_dec", 1, DEC); cyc("add_exec", 1, EXEC_R);
    cyc("add_wb", 1, ALUWB); cyc("add_next_fetch", 1, F_RDY);
    $display("[TB] add sequence checked");

    instr = 32'h40208133;  // sub x2,x1,x2
    do_reset();
    cyc("sub_fetch", 1, F_RDY); cyc("sub_dec", 1, DEC); cyc("sub_exec", 1, EXEC_SUB);
    $display("[TB] sub sequence checked");

    instr = 32'h0000A183;  // lw x3,0(x1), three wait states
    do_reset();
    cyc("lw_fetch", 1, F_RDY); cyc("lw_dec", 1, DEC); cyc("lw_memadr", 1, MADR_L);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 0, MEMRD);
    cyc("lw_memrd_rdy", 1, MEMRD); cyc("lw_memwb", 1, MEMWB); cyc("lw_next_fetch", 1, F_RDY);
    $display("[TB] lw sequence checked");

    instr = 32'h0030A023;  // sw x3,0(x1)
    do_reset();
    cyc("sw_fetch", 1, F_RDY); cyc("sw_dec", 1, DEC); cyc("sw_memadr", 1, MADR_S);
    cyc("sw_memwr", 1, MWR_RDY); cyc("sw_next_fetch", 1, F_RDY);
    $display("[TB] sw sequence checked");

    instr = 32'h0020C063; lt = 1'b1;  // blt taken
    do_reset();
    cyc("blt_fetch", 1, F_RDY); cyc("blt_dec", 1, DEC_B); cyc("blt_taken", 1, BR_T);
    cyc("blt_next_fetch", 1, F_RDY);
    lt = 1'b0;
    do_reset();
    cyc("blt_fetch2", 1, F_RDY); cyc("blt_dec2", 1, DEC_B); cyc("blt_not_taken", 1, BR_N);
    instr = 32'h00208063; eq = 1'b1;  // beq taken
    do_reset();
    cyc("beq_fetch", 1, F_RDY); cyc("beq_dec", 1, DEC_B); cyc("beq_taken", 1, BR_T);
    instr = 32'h0020F063; eq = 1'b0; ltu = 1'b1;  // bgeu not taken
    do_reset();
    cyc("bgeu_fetch", 1, F_RDY); cyc("bgeu_dec", 1, DEC_B); cyc("bgeu_not_taken", 1, BR_N);
    ltu = 1'b0;
    $display("[TB] branch sequences checked");

    sel = 2'd1; instr = 32'h0020C063; lt = 1'b1;  // blt without branch extension
    do_reset();
    cyc("noext_fetch", 1, F_RDY); cyc("noext_dec", 1, DEC_B); cyc("noext_trap", 1, TRAP_ILL);
    sel = 2'd0; lt = 1'b0;
    $display("[TB] blt without extension checked");

    instr = 32'h0000007F;  // unknown opcode
    do_reset();
    cyc("ill_fetch", 1, F_RDY); cyc("ill_dec", 1, DEC);
    for (int i = 0; i < 21; i++) cyc("ill_trap_hold", 1, TRAP_ILL);
    do_reset();
    cyc("post_trap_fetch", 1, F_RDY);
    $display("[TB] illegal opcode trap checked");

    instr = 32'h002091B3;  // funct3 001 on an ALU op
    do_reset();
    cyc("f3_fetch", 1, F_RDY); cyc("f3_dec", 1, DEC); cyc("f3_trap", 1, TRAP_ILL);
    $display("[TB] illegal funct3 trap checked");

    sel = 2'd2; instr = 32'h002081B3;  // MEM_TIMEOUT=4
    do_reset();
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 0, F_WAIT);
    cyc("to_trap", 0, TRAP_TO); cyc("to_trap_hold", 1, TRAP_TO);
    do_reset();
    for (int i = 0; i < 3; i++) cyc("to_fetch_wait2", 0, F_WAIT);
    cyc("to_ready_at_limit", 1, F_RDY); cyc("to_dec", 1, DEC); cyc("to_exec", 1, EXEC_R);
    sel = 2'd0;
    $display("[TB] memory timeout checked");

    instr = 32'h000080E7;  // jalr x1,0(x1)
    do_reset();
    cyc("jalr_fetch", 1, F_RDY); cyc("jalr_dec", 1, DEC); cyc("jalr_adr", 1, JALRADR);
    cyc("jalr_jal", 1, JAL); cyc("jalr_wb", 1, ALUWB); cyc("jalr_next_fetch", 1, F_RDY);
    $display("[TB] jalr sequence checked");

    instr = 32'h0030A023;  // reset in the middle of a store
    do_reset();
    cyc("ar_fetch", 1, F_RDY); cyc("ar_dec", 1, DEC); cyc("ar_memadr", 1, MADR_S);
    cyc("ar_memwr_wait", 0, MWR_WAIT);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", obs_sel, ZERO);
    rdy = 1'b1;
    do_reset();
    cyc("ar_refetch", 1, F_RDY);
    $display("[TB] async reset mid-access checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
